// File: rtl/age_matrix_scheduler_pkg.sv
// Shared issue-queue scheduler definitions: queue/width parameters, the
// dispatch/free entry packet, the dispatched instruction packet, and a
// population-count helper for the occupancy counter.
package age_matrix_scheduler_pkg;

  localparam int unsigned SIZE_ISSUEQ     = 16;
  localparam int unsigned SIZE_ISSUEQ_LOG = 4;
  localparam int unsigned ISSUE_WIDTH     = 4;
  localparam int unsigned ISSUE_WIDTH_LOG = 2;
  localparam int unsigned DISPATCH_WIDTH  = 4;

  // IQ entry id plus valid bit, used for both allocation and free.
  typedef struct packed {
    logic [SIZE_ISSUEQ_LOG-1:0] id;
    logic                       valid;
  } iqEntryPkt;

  // Fields of the dispatched instruction that the scheduler needs.
  typedef struct packed {
    logic [ISSUE_WIDTH_LOG-1:0] fu;
    logic                       isLoad;
    logic                       predLoadVio;
  } iqPkt;

  typedef logic [SIZE_ISSUEQ-1:0]       entry_vec_t;
  typedef logic [SIZE_ISSUEQ_LOG:0]     entry_cnt_t;

  function automatic entry_cnt_t popcount(input entry_vec_t v);
    entry_cnt_t cnt;
    cnt = '0;
    for (int unsigned i = 0; i < SIZE_ISSUEQ; i++) begin
      cnt = cnt + entry_cnt_t'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/age_matrix_scheduler_age_select.sv
// Combinational oldest-first picker for one issue lane.
//   cand  : candidate entries for this lane
//   older : older[i][j] = 1 when entry j is older than entry i
//   grant : one-hot (or zero) vector selecting the oldest candidate
module age_select
  import age_matrix_scheduler_pkg::*;
(
  input  logic [SIZE_ISSUEQ-1:0]                  cand,
  input  logic [SIZE_ISSUEQ-1:0][SIZE_ISSUEQ-1:0] older,
  output logic [SIZE_ISSUEQ-1:0]                  grant
);

  // A candidate wins when no other candidate is older than it; the matrix
  // is a total order over valid entries, so at most one bit survives.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < SIZE_ISSUEQ; i++) begin
      grant[i] = cand[i] & ~|(cand & older[i]);
    end
  end

endmodule

// File: rtl/age_matrix_scheduler.sv
// Age-matrix issue scheduler. Tracks which issue-queue entries are valid,
// their functional unit and relative age, and grants the oldest ready
// entry on each issue lane in the same cycle the request arrives.
//   clk, reset        : clock, asynchronous active-high reset
//   flush_i           : invalidate all tracked entries next cycle
//   backEndReady_i    : dispatch enable
//   freeEntry_i       : entry allocated per dispatch slot (slot 0 oldest)
//   iqPacket_i        : dispatched packet (fu, isLoad, predLoadVio)
//   freedEntry_i      : entries issued/freed this cycle
//   requestVector_i   : per-entry ready request
//   grantVector_o     : per-lane one-hot grant
//   occupancy_o       : registered count of valid entries
module age_matrix_scheduler
  import age_matrix_scheduler_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       backEndReady_i,
  input  iqEntryPkt                  freeEntry_i    [DISPATCH_WIDTH],
  input  iqPkt                       iqPacket_i     [DISPATCH_WIDTH],
  input  iqEntryPkt                  freedEntry_i   [ISSUE_WIDTH],
  input  logic [SIZE_ISSUEQ-1:0]     requestVector_i,
  output logic [SIZE_ISSUEQ-1:0]     grantVector_o  [ISSUE_WIDTH],
  output logic [SIZE_ISSUEQ_LOG:0]   occupancy_o
);

  entry_vec_t                                valid, valid_n;
  entry_vec_t                                hold, hold_n;
  logic [SIZE_ISSUEQ-1:0][ISSUE_WIDTH_LOG-1:0] fu, fu_n;
  logic [SIZE_ISSUEQ-1:0][SIZE_ISSUEQ-1:0]   older, older_n;
  entry_cnt_t                                occupancy_n;

  entry_vec_t                    freed;
  entry_vec_t                    post_free_valid;
  entry_vec_t                    disp_below;
  entry_vec_t                    blocked;
  logic [DISPATCH_WIDTH-1:0]     disp_en;

  always_comb begin
    freed = '0;
    for (int unsigned l = 0; l < ISSUE_WIDTH; l++) begin
      if (freedEntry_i[l].valid) freed[freedEntry_i[l].id] = 1'b1;
    end
    post_free_valid = valid & ~freed;
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      disp_en[k] = backEndReady_i & freeEntry_i[k].valid & ~flush_i;
    end
  end

  // Slots are applied oldest first. Each new row sees every surviving entry
  // plus the lower-numbered slots of this cycle; the column clear afterwards
  // makes the new entry younger than everything, including itself, which
  // also repairs rows written earlier in the loop when an entry is reused.
  always_comb begin
    valid_n    = post_free_valid;
    hold_n     = hold;
    fu_n       = fu;
    older_n    = older;
    disp_below = '0;
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      if (disp_en[k]) begin
        valid_n[freeEntry_i[k].id] = 1'b1;
        fu_n[freeEntry_i[k].id]    = iqPacket_i[k].fu;
        hold_n[freeEntry_i[k].id]  = iqPacket_i[k].isLoad & iqPacket_i[k].predLoadVio;
        older_n[freeEntry_i[k].id] = post_free_valid | disp_below;
        for (int unsigned j = 0; j < SIZE_ISSUEQ; j++) begin
          older_n[j][freeEntry_i[k].id] = 1'b0;
        end
        disp_below[freeEntry_i[k].id] = 1'b1;
      end
    end
    if (flush_i) valid_n = '0;
    // Counting the next valid set directly keeps overwrites and frees of
    // invalid entries from disturbing the count.
    occupancy_n = popcount(valid_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= '0;
      hold        <= '0;
      fu          <= '0;
      older       <= '0;
      occupancy_o <= '0;
    end else begin
      valid       <= valid_n;
      hold        <= hold_n;
      fu          <= fu_n;
      older       <= older_n;
      occupancy_o <= occupancy_n;
    end
  end

  // A predicted-violating load waits until nothing valid is older.
  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < SIZE_ISSUEQ; i++) begin
      blocked[i] = hold[i] & |(older[i] & valid);
    end
  end

  for (genvar L = 0; L < ISSUE_WIDTH; L++) begin : g_lane
    logic [SIZE_ISSUEQ-1:0] cand;

    always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < SIZE_ISSUEQ; i++) begin
        cand[i] = requestVector_i[i] & valid[i] & ~blocked[i] &
                  (fu[i] == ISSUE_WIDTH_LOG'(L));
      end
    end

    age_select u_select (
      .cand  (cand),
      .older (older),
      .grant (grantVector_o[L])
    );
  end

`ifdef SIM
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
        assert (!(disp_en[k] && post_free_valid[freeEntry_i[k].id]))
          else $error("dispatch into already-valid IQ entry %0d", freeEntry_i[k].id);
      end
    end
  end
`endif

endmodule

// File: tb/tb_age_matrix_scheduler.sv
module tb_age_matrix_scheduler;
  import age_matrix_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic ber = 1'b0;
  iqEntryPkt free_entry [DISPATCH_WIDTH];
  iqPkt      packet     [DISPATCH_WIDTH];
  iqEntryPkt freed_entry[ISSUE_WIDTH];
  logic [SIZE_ISSUEQ-1:0]   req = '0;
  logic [SIZE_ISSUEQ-1:0]   grant [ISSUE_WIDTH];
  logic [SIZE_ISSUEQ_LOG:0] occ;

  int checks = 0;
  int failures = 0;

  // Reference model: entries listed oldest first.
  int age_q[$];
  int m_fu[SIZE_ISSUEQ];
  bit m_hold[SIZE_ISSUEQ];

  age_matrix_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush),
    .backEndReady_i  (ber),
    .freeEntry_i     (free_entry),
    .iqPacket_i      (packet),
    .freedEntry_i    (freed_entry),
    .requestVector_i (req),
    .grantVector_o   (grant),
    .occupancy_o     (occ)
  );

  always #5 clk = ~clk;

  function automatic logic [SIZE_ISSUEQ-1:0] onehot(input int i);
    logic [SIZE_ISSUEQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic void q_remove(input int id);
    for (int i = 0; i < age_q.size(); i++) begin
      if (age_q[i] == id) begin
        age_q.delete(i);
        break;
      end
    end
  endfunction

  // Oldest requesting entry on this lane that is not a held load behind others.
  function automatic logic [SIZE_ISSUEQ-1:0] model_grant(input int lane);
    for (int p = 0; p < age_q.size(); p++) begin
      int e;
      e = age_q[p];
      if (req[e] && m_fu[e] == lane && !(m_hold[e] && p != 0)) return onehot(e);
    end
    return '0;
  endfunction

  function automatic void model_update();
    if (reset || flush) begin
      age_q.delete();
    end else begin
      for (int l = 0; l < ISSUE_WIDTH; l++)
        if (freed_entry[l].valid) q_remove(int'(freed_entry[l].id));
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (ber && free_entry[k].valid) begin
          int e;
          e = int'(free_entry[k].id);
          q_remove(e);
          age_q.push_back(e);
          m_fu[e]   = int'(packet[k].fu);
          m_hold[e] = packet[k].isLoad & packet[k].predLoadVio;
        end
      end
    end
  endfunction

  task automatic clear_ctrl();
    flush = 1'b0;
    ber   = 1'b0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      free_entry[k] = '0;
      packet[k]     = '0;
    end
    for (int l = 0; l < ISSUE_WIDTH; l++) freed_entry[l] = '0;
  endtask

  task automatic set_dispatch(input int slot, input int id, input int f, input bit ld, input bit vio);
    ber = 1'b1;
    free_entry[slot].id          = SIZE_ISSUEQ_LOG'(id);
    free_entry[slot].valid       = 1'b1;
    packet[slot].fu              = ISSUE_WIDTH_LOG'(f);
    packet[slot].isLoad          = ld;
    packet[slot].predLoadVio     = vio;
  endtask

  task automatic set_free(input int lane, input int id);
    freed_entry[lane].id    = SIZE_ISSUEQ_LOG'(id);
    freed_entry[lane].valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    clear_ctrl();
  endtask

  task automatic test_reset();
    clear_ctrl();
    req = '1;
    set_dispatch(0, 3, 0, 1'b0, 1'b0);
    tick();
    tick();
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      checks++;
      if (grant[l] !== '0) begin
        failures++;
        $display("FAIL reset_grant lane%0d got=%h want=0", l, grant[l]);
      end
    end
    checks++;
    if (occ !== '0) begin
      failures++;
      $display("FAIL reset_occ got=%0d want=0", occ);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (occ !== '0) begin
      failures++;
      $display("FAIL reset_discard_dispatch occ got=%0d want=0", occ);
    end
    req = '0;
  endtask

  task automatic test_age_order();
    logic [SIZE_ISSUEQ-1:0] want [3];
    int frees [3];
    want[0] = onehot(5); want[1] = onehot(2); want[2] = onehot(9);
    frees[0] = 5; frees[1] = 2; frees[2] = 9;
    set_dispatch(0, 5, 0, 1'b0, 1'b0);
    set_dispatch(1, 2, 0, 1'b0, 1'b0);
    set_dispatch(2, 9, 0, 1'b0, 1'b0);
    tick();
    req = onehot(5) | onehot(2) | onehot(9);
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if (grant[0] !== want[s]) begin
        failures++;
        $display("FAIL age_order step%0d got=%h want=%h", s, grant[0], want[s]);
      end
      checks++;
      if (occ !== (SIZE_ISSUEQ_LOG+1)'(3 - s)) begin
        failures++;
        $display("FAIL age_order_occ step%0d got=%0d want=%0d", s, occ, 3 - s);
      end
      set_free(0, frees[s]);
      tick();
    end
    checks++;
    if (grant[0] !== '0) begin
      failures++;
      $display("FAIL age_order_empty got=%h want=0", grant[0]);
    end
    req = '0;
  endtask

  task automatic test_lanes();
    set_dispatch(0, 3, 1, 1'b0, 1'b0);
    tick();
    set_dispatch(0, 7, 0, 1'b0, 1'b0);
    tick();
    req = onehot(3) | onehot(7);
    #1;
    checks++;
    if (grant[1] !== onehot(3)) begin
      failures++;
      $display("FAIL lane1_grant got=%h want=%h", grant[1], onehot(3));
    end
    checks++;
    if (grant[0] !== onehot(7)) begin
      failures++;
      $display("FAIL lane0_grant got=%h want=%h", grant[0], onehot(7));
    end
    flush = 1'b1;
    tick();
    req = '0;
  endtask

  task automatic test_load_hold();
    set_dispatch(0, 1, 0, 1'b0, 1'b0);
    tick();
    set_dispatch(0, 4, 0, 1'b1, 1'b1);
    tick();
    req = onehot(4);
    #1;
    checks++;
    if (grant[0] !== '0) begin
      failures++;
      $display("FAIL load_held got=%h want=0", grant[0]);
    end
    set_free(0, 1);
    tick();
    checks++;
    if (grant[0] !== onehot(4)) begin
      failures++;
      $display("FAIL load_released got=%h want=%h", grant[0], onehot(4));
    end
    req = '0;
  endtask

  task automatic test_free_dispatch_same();
    set_dispatch(0, 6, 0, 1'b0, 1'b0);
    tick();
    set_dispatch(0, 8, 0, 1'b0, 1'b0);
    tick();
    checks++;
    if (occ !== (SIZE_ISSUEQ_LOG+1)'(3)) begin
      failures++;
      $display("FAIL reuse_occ_before got=%0d want=3", occ);
    end
    set_free(0, 6);
    set_dispatch(0, 6, 0, 1'b0, 1'b0);
    tick();
    checks++;
    if (occ !== (SIZE_ISSUEQ_LOG+1)'(3)) begin
      failures++;
      $display("FAIL reuse_occ_after got=%0d want=3", occ);
    end
    req = onehot(6) | onehot(8);
    #1;
    checks++;
    if (grant[0] !== onehot(8)) begin
      failures++;
      $display("FAIL reuse_youngest got=%h want=%h", grant[0], onehot(8));
    end
    req = onehot(6);
    #1;
    checks++;
    if (grant[0] !== onehot(6)) begin
      failures++;
      $display("FAIL reuse_valid got=%h want=%h", grant[0], onehot(6));
    end
    flush = 1'b1;
    tick();
    req = '0;
  endtask

  task automatic test_flush_full();
    for (int c = 0; c < SIZE_ISSUEQ / DISPATCH_WIDTH; c++) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++)
        set_dispatch(k, c * DISPATCH_WIDTH + k, (c * DISPATCH_WIDTH + k) % ISSUE_WIDTH, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (occ !== (SIZE_ISSUEQ_LOG+1)'(SIZE_ISSUEQ)) begin
      failures++;
      $display("FAIL full_occ got=%0d want=%0d", occ, SIZE_ISSUEQ);
    end
    req = '1;
    flush = 1'b1;
    #1;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      checks++;
      if (grant[l] !== onehot(l)) begin
        failures++;
        $display("FAIL flush_cycle_grant lane%0d got=%h want=%h", l, grant[l], onehot(l));
      end
    end
    tick();
    checks++;
    if (occ !== '0) begin
      failures++;
      $display("FAIL flush_occ got=%0d want=0", occ);
    end
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      checks++;
      if (grant[l] !== '0) begin
        failures++;
        $display("FAIL flush_grant lane%0d got=%h want=0", l, grant[l]);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++)
        if (c * DISPATCH_WIDTH + k < 10)
          set_dispatch(k, c * DISPATCH_WIDTH + k, (c * DISPATCH_WIDTH + k) % ISSUE_WIDTH, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (occ !== (SIZE_ISSUEQ_LOG+1)'(10)) begin
      failures++;
      $display("FAIL midreset_occ_before got=%0d want=10", occ);
    end
    req = '1;
    set_dispatch(0, 12, 2, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    age_q.delete();
    #1;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      checks++;
      if (grant[l] !== '0) begin
        failures++;
        $display("FAIL midreset_grant lane%0d got=%h want=0", l, grant[l]);
      end
    end
    checks++;
    if (occ !== '0) begin
      failures++;
      $display("FAIL midreset_occ got=%0d want=0", occ);
    end
    tick();
    reset = 1'b0;
    #1;
    set_dispatch(0, 12, 2, 1'b0, 1'b0);
    tick();
    set_dispatch(0, 3, 2, 1'b0, 1'b0);
    tick();
    req = onehot(12) | onehot(3);
    #1;
    checks++;
    if (grant[2] !== onehot(12)) begin
      failures++;
      $display("FAIL midreset_oldest got=%h want=%h", grant[2], onehot(12));
    end
    checks++;
    if (occ !== (SIZE_ISSUEQ_LOG+1)'(2)) begin
      failures++;
      $display("FAIL midreset_occ_after got=%0d want=2", occ);
    end
    flush = 1'b1;
    tick();
    req = '0;
  endtask

  task automatic test_random();
    bit used[SIZE_ISSUEQ];
    for (int cyc = 0; cyc < 400; cyc++) begin
      req = SIZE_ISSUEQ'($urandom);
      for (int i = 0; i < SIZE_ISSUEQ; i++) used[i] = 1'b0;
      foreach (age_q[i]) used[age_q[i]] = 1'b1;
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (age_q.size() > 0 && $urandom_range(0, 2) == 0)
          set_free(l, age_q[$urandom_range(0, age_q.size() - 1)]);
        else if ($urandom_range(0, 7) == 0)
          set_free(l, $urandom_range(0, SIZE_ISSUEQ - 1));
        if (freed_entry[l].valid) used[freed_entry[l].id] = 1'b0;
      end
      ber = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          int start;
          start = $urandom_range(0, SIZE_ISSUEQ - 1);
          for (int n = 0; n < SIZE_ISSUEQ; n++) begin
            int e;
            e = (start + n) % SIZE_ISSUEQ;
            if (!used[e]) begin
              used[e] = 1'b1;
              free_entry[k].id         = SIZE_ISSUEQ_LOG'(e);
              free_entry[k].valid      = 1'b1;
              packet[k].fu             = ISSUE_WIDTH_LOG'($urandom_range(0, ISSUE_WIDTH - 1));
              packet[k].isLoad         = ($urandom_range(0, 3) == 0);
              packet[k].predLoadVio    = ($urandom_range(0, 3) == 0);
              break;
            end
          end
        end
      end
      flush = ($urandom_range(0, 31) == 0);
      #1;
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        logic [SIZE_ISSUEQ-1:0] want;
        want = model_grant(l);
        checks++;
        if (grant[l] !== want) begin
          failures++;
          $display("FAIL random_grant cyc%0d lane%0d got=%h want=%h", cyc, l, grant[l], want);
        end
      end
      tick();
      checks++;
      if (occ !== (SIZE_ISSUEQ_LOG+1)'(age_q.size())) begin
        failures++;
        $display("FAIL random_occ cyc%0d got=%0d want=%0d", cyc, occ, age_q.size());
      end
    end
    req = '0;
  endtask

  initial begin
    clear_ctrl();
    test_reset();
    test_age_order();
    test_lanes();
    test_load_hold();
    test_free_dispatch_same();
    test_flush_full();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
